// File: rtl/pattern_counter_gen.sv
// Parametrised Johnson/ring shift-pattern counter paced by an internal prescaler enable.
// Optional illegal-state recovery is built when PATTERN_COUNTER_GEN_RECOVER_EN is defined.
module pattern_counter_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             step,
    output logic             wrap
);

    localparam int unsigned     PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [PW-1:0]    cnt;
    logic             tick;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

`ifdef PATTERN_COUNTER_GEN_RECOVER_EN
    logic [WIDTH-2:0] edges;
    logic             john_bad;
    logic             ring_bad;

    // Johnson-legal states have at most one adjacent-bit transition.
    assign edges    = q[WIDTH-2:0] ^ q[WIDTH-1:1];
    assign john_bad = (edges & (edges - 1'b1)) != '0;
    assign ring_bad = (q != '0) && ((q & (q - 1'b1)) != '0);
`endif

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        shifted = '0;
        case ({mode, dir})
            2'b00:   shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
            2'b01:   shifted = {~q[0], q[WIDTH-1:1]};
            2'b10:   shifted = {q[WIDTH-2:0], q[WIDTH-1]};
            default: shifted = {q[0], q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        q_next = shifted;
        if (mode && (q == '0)) begin
            q_next = ONE;
        end
`ifdef PATTERN_COUNTER_GEN_RECOVER_EN
        if (mode && ring_bad) begin
            q_next = ONE;
        end else if (!mode && john_bad) begin
            q_next = '0;
        end
`endif
        // Recovery and seed both land on the start state, so this covers their wrap too.
        wrap_next = mode ? (q_next == ONE) : (q_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (tick) begin
            q    <= q_next;
            step <= 1'b1;
            wrap <= wrap_next;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: doc/pattern_counter_gen.md
# pattern_counter_gen

Parametrised shift-pattern counter for the CPLD lab designs. It generalises the fixed 8-bit Johnson counter to any width, with Johnson or ring mode, forward or reverse direction, run/hold and parallel load. Stepping is paced by an internal prescaler that produces a single-cycle enable; there is no derived clock, and all logic runs on `clk`. Intended to drive LED banks and to sequence other lab blocks through its `step` and `wrap` strobes.

## Interface

**Parameters**
- `WIDTH`, default 8: pattern width in bits. Must be ≥ 2.
- `DIV`, default 50_000_000: `clk` cycles per step. Must be ≥ 1. Prescaler width is `$clog2(DIV)`, minimum 1.

**Ports**
- `clk`  in  1: system clock (50 MHz on the lab board).
- `rst_n`  in  1: reset, asynchronous, active-low.
- `en`  in  1: run when 1, hold when 0. Prescaler and `q` both freeze on hold.
- `dir`  in  1: 0 = forward (shift toward MSB), 1 = reverse (shift toward LSB).
- `mode`  in  1: 0 = Johnson, 1 = ring.
- `load`  in  1: synchronous parallel load strobe.
- `load_val`  in  WIDTH: value written to `q` on `load`.
- `q`  out  WIDTH: pattern output, registered.
- `step`  out  1: one-cycle pulse, high in the same cycle `q` takes its advanced value.
- `wrap`  out  1: one-cycle pulse, high with `step` when the new `q` is the period start state.

## Operation

**Reset (`rst_n` = 0)**
- `q` = 0, prescaler = 0, `step` = 0, `wrap` = 0.
- Reset is asynchronous assert. Reset mid-period discards the partial prescaler count.

**Prescaler**
- With `en` = 1, counts 0 … DIV−1.
- Internal `tick` = `en` && (count == DIV−1); on `tick` the count returns to 0.
- With `en` = 0, the count holds.
- With DIV = 1, `tick` = `en` on every cycle.

**Priority, highest first:** reset, `load`, `tick`.
- `load`: `q` ← `load_val`, prescaler ← 0, `step` = `wrap` = 0.
  - Works regardless of `en`.
  - A coincident `tick` is discarded.
- `tick` with no `load`: `q` advances and `step` = 1.

**Next-state rules on `tick`**
- Johnson forward: `{q[W-2:0], ~q[W-1]}`. Johnson reverse: `{~q[0], q[W-1:1]}`.
- Ring forward: `{q[W-2:0], q[W-1]}`. Ring reverse: `{q[0], q[W-1:1]}`.
- Ring seed: in ring mode with `q` == 0 at `tick`, next `q` = 1.
- Period: Johnson 2·WIDTH steps; ring WIDTH steps, from a one-hot state.

**`wrap` start state**
- Johnson: new `q` == 0, in either direction.
- Ring: new `q` == 1.
- The seed step in ring mode also asserts `wrap`.

**Mode and direction changes**
- `mode`/`dir` are sampled only at `tick`. The change applies from the next advance, and the prescaler phase is kept.
- `q` is not re-initialised, except by the ring seed rule.

## Timing

- All outputs are registered; no combinational path from inputs to outputs.
- From reset release with `en` = 1 held, the first `step` is high DIV cycles after the first active edge; thereafter every DIV cycles.
- `load` takes effect on the edge it is sampled on. The next `step` comes DIV cycles later if `en` = 1.
- Dropping `en` for N cycles delays every subsequent `step` by exactly N cycles.
- `step`/`wrap` are never high for more than one cycle per `tick`.

## Configuration

- Macro: `PATTERN_COUNTER_GEN_RECOVER_EN`.
- Defined: at `tick`, an illegal state is replaced instead of shifted.
  - Johnson illegal = more than one position i in 0…W−2 with `q[i]` ≠ `q[i+1]`; next `q` = 0.
  - Ring illegal = nonzero and not one-hot; next `q` = 1.
  - `step` = 1 and `wrap` = 1 on a recovery step.
- Undefined: illegal states shift per the normal rules indefinitely. No recovery logic is synthesised.

## Test plan

Bench parameters: WIDTH=8, DIV=4.
- **Reset and Johnson forward:** reset, then `en`=1, `mode`=0, `dir`=0 → `q` steps 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,…,80,00 every 4 cycles. `wrap` pulses only on the 00 after the 16th step.
- **Ring, reverse, seed:** `mode`=1, `dir`=1 from `q`=00 → first `step` gives 01 with `wrap`=1, then 80,40,…,02,01. `wrap` repeats every 8 steps.
- **Load/tick collision:** assert `load` with `load_val`=0x0F on the cycle the prescaler is at 3 → `q`=0F, `step`=0. The next `step` comes 4 cycles later with `q`=1F.
- **Hold:** `en`=0 for 10 cycles mid-period → `q` and prescaler frozen. The following `step` is delayed by exactly 10 cycles.
- **Async reset mid-period:** pulse `rst_n` low between edges with `q`=3F → `q`, `step` and `wrap` go 0 immediately. After release, the first `step` is 4 cycles later.
- **Recovery:** load 0x5A in Johnson mode.
  - With the macro defined → next `step` gives `q`=00, `wrap`=1.
  - Without the macro → next `q`=B5.
